// File: rtl/mem_pkg.sv
// Shared encodings and defaults for the CPU memory responder.
package mem_pkg;

  typedef enum logic [1:0] {
    MNONE  = 2'b00,
    MREAD  = 2'b01,
    MWRITE = 2'b10,
    MRSVD  = 2'b11
  } mem_cmd_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    DONE = 2'b10
  } state_e;

  localparam logic [8:0] DEF_LED_ADDR = 9'h100;
  localparam logic [8:0] DEF_SW_ADDR  = 9'h140;

endpackage

// File: rtl/mem_ram.sv
// Single-port RAM with synchronous write and registered read; contents are never reset.
module mem_ram #(
  parameter int RAM_WORDS = 256,
  parameter int DATA_W    = 16
) (
  input  logic                         clk,
  input  logic                         i_we,
  input  logic                         i_re,
  input  logic [$clog2(RAM_WORDS)-1:0] i_addr,
  input  logic [DATA_W-1:0]            i_wdata,
  output logic [DATA_W-1:0]            o_rdata
);

  logic [DATA_W-1:0] r_mem [RAM_WORDS];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
    if (i_re) o_rdata <= r_mem[i_addr];
  end

endmodule

// File: rtl/mem_responder.sv
// CPU memory responder: RAM, LED and switch registers behind an IDLE/WAIT/DONE handshake.
// Define MEM_ERR_EN to add the sticky mem_err output.
module mem_responder
  import mem_pkg::*;
#(
  parameter int                DATA_W      = 16,
  parameter int                ADDR_W      = 9,
  parameter int                RAM_WORDS   = 256,
  parameter int                WAIT_STATES = 1,
  parameter logic [ADDR_W-1:0] LED_ADDR    = DEF_LED_ADDR,
  parameter logic [ADDR_W-1:0] SW_ADDR     = DEF_SW_ADDR
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        mem_cmd,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] write_data,
  input  logic [7:0]        SW,
  output logic [DATA_W-1:0] read_data,
  output logic              mem_ready,
  output logic [7:0]        LEDR
`ifdef MEM_ERR_EN
  ,
  output logic              mem_err
`endif
);

  localparam int         RAM_AW = $clog2(RAM_WORDS);
  localparam logic [3:0] WS     = 4'(WAIT_STATES);

  state_e            r_state;
  state_e            w_state_next;
  logic [1:0]        r_cmd;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [3:0]        r_wait_cnt;
  logic [7:0]        r_led;
  logic              r_rd_ram;
  logic [DATA_W-1:0] r_rd_io;
  logic [DATA_W-1:0] w_ram_q;

  logic w_start, w_done, w_is_rd, w_is_wr;
  logic w_hit_ram, w_hit_led, w_hit_sw;

  assign w_start   = (r_state == IDLE) && ((mem_cmd == MREAD) || (mem_cmd == MWRITE));
  assign w_done    = (r_state == DONE);
  assign w_is_rd   = (r_cmd == MREAD);
  assign w_is_wr   = (r_cmd == MWRITE);
  assign w_hit_ram = int'(r_addr) < RAM_WORDS;
  assign w_hit_led = (r_addr == LED_ADDR);
  assign w_hit_sw  = (r_addr == SW_ADDR);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    mem_ready    = 1'b0;
    case (r_state)
      IDLE: if (w_start) w_state_next = (WAIT_STATES > 0) ? WAIT : DONE;
      WAIT: if (r_wait_cnt == WS) w_state_next = DONE;
      DONE: begin
        mem_ready    = 1'b1;
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Request is frozen at acceptance; pin changes after that are ignored.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cmd      <= MNONE;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_wait_cnt <= '0;
      r_led      <= '0;
      r_rd_ram   <= 1'b0;
      r_rd_io    <= '0;
    end else begin
      if (w_start) begin
        r_cmd      <= mem_cmd;
        r_addr     <= mem_addr;
        r_wdata    <= write_data;
        r_wait_cnt <= 4'd1;
      end else if (r_state == WAIT) begin
        r_wait_cnt <= r_wait_cnt + 4'd1;
      end else if (w_done) begin
        r_wait_cnt <= '0;
      end
      if (w_done && w_is_wr && w_hit_led) r_led <= r_wdata[7:0];
      if (w_done && w_is_rd) begin
        r_rd_ram <= w_hit_ram;
        r_rd_io  <= w_hit_led ? DATA_W'(r_led) : (w_hit_sw ? DATA_W'(SW) : '0);
      end
    end
  end

  mem_ram #(
    .RAM_WORDS(RAM_WORDS),
    .DATA_W   (DATA_W)
  ) u_ram (
    .clk    (clk),
    .i_we   (w_done && w_is_wr && w_hit_ram),
    .i_re   (w_done && w_is_rd && w_hit_ram),
    .i_addr (r_addr[RAM_AW-1:0]),
    .i_wdata(r_wdata),
    .o_rdata(w_ram_q)
  );

  // RAM output only moves on a RAM read, so this mux holds the last load.
  assign read_data = r_rd_ram ? w_ram_q : r_rd_io;
  assign LEDR      = r_led;

`ifdef MEM_ERR_EN
  logic r_err;
  logic w_unmapped;
  assign w_unmapped = !(w_hit_ram || w_hit_led || w_hit_sw);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_err <= 1'b0;
    end else if (((r_state == IDLE) && (mem_cmd == MRSVD)) ||
                 (w_done && (w_unmapped || (w_is_wr && w_hit_sw) || (w_is_rd && w_hit_led)))) begin
      r_err <= 1'b1;
    end
  end

  assign mem_err = r_err;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: three instances with WAIT_STATES 1, 0 and 3.
module tb_mem_responder;
  import mem_pkg::*;

  typedef struct {
    int          dut;
    bit          is_rd;
    logic [15:0] data;
    int          cyc;
  } exp_t;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  sw    = 8'h00;
  logic [1:0]  cmd_a  [3];
  logic [8:0]  addr_a [3];
  logic [15:0] wd_a   [3];
  logic [15:0] rd_a   [3];
  logic        rdy_a  [3];
  logic [7:0]  led_a  [3];
`ifdef MEM_ERR_EN
  logic        err_a  [3];
`endif

  exp_t        exp_q[$];
  int          cyc    = 0;
  int          n_chk  = 0;
  int          n_fail = 0;
  bit          pend_rd  [3];
  logic [15:0] pend_val [3];
  bit          prev_rdy [3];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    mem_responder #(
      .WAIT_STATES((gi == 0) ? 1 : ((gi == 1) ? 0 : 3))
    ) u_dut (
      .clk       (clk),
      .reset     (rst_n),
      .mem_cmd   (cmd_a[gi]),
      .mem_addr  (addr_a[gi]),
      .write_data(wd_a[gi]),
      .SW        (sw),
      .read_data (rd_a[gi]),
      .mem_ready (rdy_a[gi]),
      .LEDR      (led_a[gi])
`ifdef MEM_ERR_EN
      ,
      .mem_err   (err_a[gi])
`endif
    );
  end

  function automatic int ws_of(input int d);
    return (d == 0) ? 1 : ((d == 1) ? 0 : 3);
  endfunction

  task automatic chk16(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: pop the matching expectation whenever an instance completes.
  always @(negedge clk) begin : mon
    int   idx;
    exp_t e;
    for (int d = 0; d < 3; d++) begin
      if (pend_rd[d]) begin
        n_chk++;
        if (rd_a[d] !== pend_val[d]) begin
          n_fail++;
          $display("FAIL read_data dut%0d: got %h expected %h", d, rd_a[d], pend_val[d]);
        end
        pend_rd[d] = 1'b0;
      end
      if (rdy_a[d] === 1'b1) begin
        n_chk++;
        if (prev_rdy[d]) begin
          n_fail++;
          $display("FAIL ready_consec dut%0d: got two consecutive ready cycles, expected one", d);
        end
        idx = -1;
        for (int i = 0; i < exp_q.size(); i++)
          if (idx < 0 && exp_q[i].dut == d) idx = i;
        n_chk++;
        if (idx < 0) begin
          n_fail++;
          $display("FAIL ready_unexpected dut%0d: got ready at cycle %0d, expected none", d, cyc);
        end else begin
          e = exp_q[idx];
          exp_q.delete(idx);
          if (cyc != e.cyc) begin
            n_fail++;
            $display("FAIL ready_latency dut%0d: got cycle %0d expected cycle %0d", d, cyc, e.cyc);
          end
          if (e.is_rd) begin
            pend_rd[d]  = 1'b1;
            pend_val[d] = e.data;
          end
        end
      end
      prev_rdy[d] = (rdy_a[d] === 1'b1);
    end
  end

  // Issue one command, optionally altering address/data at negedge chg_at, and drop it on ready.
  task automatic txn(input int d, input logic [1:0] c, input logic [8:0] a, input logic [15:0] w,
                     input logic [15:0] exp, input int chg_at, input logic [8:0] a2,
                     input logic [15:0] w2);
    exp_t e;
    int   n;
    e.dut   = d;
    e.is_rd = (c == MREAD);
    e.data  = exp;
    e.cyc   = cyc + 1 + ws_of(d);
    exp_q.push_back(e);
    cmd_a[d]  = c;
    addr_a[d] = a;
    wd_a[d]   = w;
    for (n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (chg_at == n) begin
        addr_a[d] = a2;
        wd_a[d]   = w2;
      end
      if (rdy_a[d] === 1'b1) break;
    end
    cmd_a[d] = MNONE;
    if (n > 40) begin
      n_chk++;
      n_fail++;
      $display("FAIL ready_timeout dut%0d: got no ready in 40 cycles, expected one", d);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int d, input logic [8:0] a, input logic [15:0] w);
    txn(d, MWRITE, a, w, 16'h0000, 0, 9'h000, 16'h0000);
  endtask

  task automatic rd(input int d, input logic [8:0] a, input logic [15:0] exp);
    txn(d, MREAD, a, 16'h0000, exp, 0, 9'h000, 16'h0000);
  endtask

  initial begin
    int c0;
    exp_t e;
    for (int d = 0; d < 3; d++) begin
      cmd_a[d]  = MNONE;
      addr_a[d] = '0;
      wd_a[d]   = '0;
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      chk16($sformatf("reset_rdata dut%0d", d), rd_a[d], 16'h0000);
      chk16($sformatf("reset_ledr dut%0d", d), {8'h00, led_a[d]}, 16'h0000);
      chk16($sformatf("reset_ready dut%0d", d), {15'h0, rdy_a[d]}, 16'h0000);
    end

    // WAIT_STATES=1: RAM, boundary, LED, switches, unmapped
    wr(0, 9'h005, 16'hBEEF);
    rd(0, 9'h005, 16'hBEEF);
    wr(0, 9'h0FF, 16'h5A5A);
    rd(0, 9'h0FF, 16'h5A5A);
    wr(0, 9'h100, 16'h12A5);
    chk16("ledr_write", {8'h00, led_a[0]}, 16'h00A5);
    rd(0, 9'h100, 16'h00A5);
    sw = 8'h3C;
    rd(0, 9'h140, 16'h003C);
    rd(0, 9'h1F0, 16'h0000);
`ifdef MEM_ERR_EN
    chk16("mem_err_set", {15'h0, err_a[0]}, 16'h0001);
`endif
    wr(0, 9'h140, 16'h7777);
    rd(0, 9'h140, 16'h003C);
    rd(0, 9'h005, 16'hBEEF);
    wr(0, 9'h006, 16'h1234);
    chk16("rdata_hold_after_write", rd_a[0], 16'hBEEF);

    // Reset during WAIT aborts the write
    wr(0, 9'h010, 16'h0000);
    cmd_a[0]  = MWRITE;
    addr_a[0] = 9'h010;
    wd_a[0]   = 16'h1111;
    @(posedge clk);
    #1 rst_n = 1'b0;
    cmd_a[0] = MNONE;
    @(posedge clk);
    #1;
    chk16("ready_in_reset", {15'h0, rdy_a[0]}, 16'h0000);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk16("rdata_after_reset", rd_a[0], 16'h0000);
    chk16("ledr_after_reset", {8'h00, led_a[0]}, 16'h0000);
`ifdef MEM_ERR_EN
    chk16("mem_err_cleared", {15'h0, err_a[0]}, 16'h0000);
`endif
    rd(0, 9'h010, 16'h0000);

    // WAIT_STATES=0: held MREAD completes every other cycle
    wr(1, 9'h005, 16'hABCD);
    c0 = cyc;
    for (int k = 0; k < 3; k++) begin
      e.dut   = 1;
      e.is_rd = 1'b1;
      e.data  = 16'hABCD;
      e.cyc   = c0 + 1 + 2 * k;
      exp_q.push_back(e);
    end
    cmd_a[1]  = MREAD;
    addr_a[1] = 9'h005;
    repeat (6) @(posedge clk);
    #1 cmd_a[1] = MNONE;
    repeat (3) @(posedge clk);
    #1;

    // WAIT_STATES=3: pin changes mid-WAIT are ignored
    wr(2, 9'h021, 16'h0000);
    txn(2, MWRITE, 9'h020, 16'h2222, 16'h0000, 2, 9'h021, 16'h3333);
    rd(2, 9'h020, 16'h2222);
    rd(2, 9'h021, 16'h0000);

    repeat (4) @(posedge clk);
    #1;
    chk16("scoreboard_empty", 16'(exp_q.size()), 16'h0000);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
